// File: rtl/mips_cpu_lsu_pkg.sv
// mips_cpu_lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_op_t     - 4-bit datapath operation code
//   lsu_state_t  - LSU control state
//   is_load      - op reads memory
//   is_misaligned- op/offset pair must be rejected (misaligned or illegal code)
// Build option: LSU_UNALIGNED_EN makes LWL/LWR legal; otherwise they are
// rejected as illegal codes.
package mips_cpu_lsu_pkg;

   typedef enum logic [3:0] {
      LB  = 4'd0,
      LBU = 4'd1,
      LH  = 4'd2,
      LHU = 4'd3,
      LW  = 4'd4,
      SB  = 4'd5,
      SH  = 4'd6,
      SW  = 4'd7,
      LWL = 4'd8,
      LWR = 4'd9
   } lsu_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_WAIT_DATA,
      S_RESP
   } lsu_state_t;

   function automatic logic is_load(input logic [3:0] op);
      case (op)
         LB, LBU, LH, LHU, LW, LWL, LWR: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // Returns 1 for anything that must not reach the bus, including codes
   // outside lsu_op_t.
   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] b);
      case (op)
         LB, LBU, SB: return 1'b0;
         LH, LHU, SH: return b[0];
         LW, SW:      return (b != 2'd0);
`ifdef LSU_UNALIGNED_EN
         LWL, LWR:    return 1'b0;
`else
         LWL, LWR:    return 1'b1;
`endif
         default:     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// mips_cpu_lsu_align: combinational load-result formatter.
//   op       in  4   operation code
//   b        in  2   byte offset of the request
//   readdata in  32  raw bus word
//   rt_old   in  32  previous rt value, merged in for LWL/LWR
//   data     out 32  extracted, extended or merged load result
// LWL/LWR merging is always present here; whether those ops can reach this
// block is decided by is_misaligned in the package.
module mips_cpu_lsu_align
   import mips_cpu_lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  b,
   input  logic [31:0] readdata,
   input  logic [31:0] rt_old,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [4:0]  sh_r;
   logic [4:0]  sh_l;

   always_comb begin
      byte_sel = readdata[{b, 3'b000} +: 8];
      half_sel = readdata[{b[1], 4'b0000} +: 16];
      sh_r     = {b, 3'b000};
      // LWL moves lane b up to lane 3, i.e. left by 3-b bytes
      sh_l     = {2'd3 - b, 3'b000};
      data     = 32'd0;
      case (op)
         LB:  data = {{24{byte_sel[7]}}, byte_sel};
         LBU: data = {24'd0, byte_sel};
         LH:  data = {{16{half_sel[15]}}, half_sel};
         LHU: data = {16'd0, half_sel};
         LW:  data = readdata;
         // keep rt_old only in the byte positions the shifted word does not cover
         LWL: data = (readdata << sh_l) | (rt_old & ~(32'hFFFF_FFFF << sh_l));
         LWR: data = (readdata >> sh_r) | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
         default: data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: single-request load/store unit in front of the memory bus.
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_op/req_addr/req_wdata/req_rt_old  datapath request
//   resp_valid/resp_data/resp_err   one-cycle response
//   address/read/write/byteenable/writedata  bus command (registered)
//   waitrequest/readdata            bus stall and load data
// Parameter READ_LATENCY (0 or 1): cycles from accepted read to readdata.
// Build option: LSU_UNALIGNED_EN enables LWL/LWR (see package).
module mips_cpu_lsu
   import mips_cpu_lsu_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_rt_old,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   lsu_state_t  state;
   logic [3:0]  op_q;
   logic [1:0]  b_q;
   logic [31:0] rt_q;
   logic [1:0]  b_in;
   logic [3:0]  be_nxt;
   logic [31:0] wd_nxt;
   logic [31:0] load_data;

   assign req_ready = (state == S_IDLE);
   assign b_in      = req_addr[1:0];

   // Bus lane mask and replicated store data for the incoming request
   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = req_wdata;
      case (req_op)
         LB, LBU, SB: be_nxt = 4'b0001 << b_in;
         LH, LHU, SH: be_nxt = b_in[1] ? 4'b1100 : 4'b0011;
         LWL:         be_nxt = 4'b1111 >> (2'd3 - b_in);
         LWR:         be_nxt = 4'b1111 << b_in;
         default:     be_nxt = 4'b1111;
      endcase
      case (req_op)
         SB:      wd_nxt = {4{req_wdata[7:0]}};
         SH:      wd_nxt = {2{req_wdata[15:0]}};
         default: wd_nxt = req_wdata;
      endcase
   end

   // Fed with live readdata: the result is registered on the cycle the bus
   // presents the word, so no separate capture register is needed.
   mips_cpu_lsu_align u_align (
      .op       (op_q),
      .b        (b_q),
      .readdata (readdata),
      .rt_old   (rt_q),
      .data     (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         op_q       <= 4'd0;
         b_q        <= 2'd0;
         rt_q       <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_data  <= 32'd0;
         address    <= 32'd0;
         read       <= 1'b0;
         write      <= 1'b0;
         byteenable <= 4'd0;
         writedata  <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q <= req_op;
                  b_q  <= b_in;
                  rt_q <= req_rt_old;
                  if (is_misaligned(req_op, b_in)) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_data  <= 32'd0;
                  end else begin
                     state      <= S_BUS;
                     address    <= {req_addr[31:2], 2'b00};
                     byteenable <= be_nxt;
                     writedata  <= wd_nxt;
                     read       <= is_load(req_op);
                     write      <= !is_load(req_op);
                  end
               end
            end
            S_BUS: begin
               if (!waitrequest) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  if (!is_load(op_q)) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_data  <= 32'd0;
                  end else if (READ_LATENCY == 0) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_data  <= load_data;
                  end else begin
                     state <= S_WAIT_DATA;
                  end
               end
            end
            S_WAIT_DATA: begin
               state      <= S_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_data  <= load_data;
            end
            S_RESP: begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_data  <= 32'd0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb_mips_cpu_lsu: directed bench for mips_cpu_lsu with a byte-level
// reference model and a per-cycle compare process.
module tb_mips_cpu_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [31:0] req_rt_old = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = 32'd0;

   localparam logic [31:0] POISON = 32'h5A5A_5A5A;

   mips_cpu_lsu #(.READ_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // expectation for the transaction in flight
   bit          act = 1'b0;
   int          k = 0;
   bit          e_err, e_ld;
   logic [3:0]  e_be;
   logic [31:0] e_wd, e_data, e_addr;
   int          e_lat, e_nwait;
   int          wr_cnt, rv_cnt;
   logic [31:0] last_data;
   logic        last_err;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: actual %h required %h", nm, a, e);
      end
   endtask

   // Reference: treats the bus word as four bytes and builds the result byte by byte.
   function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd_in, input logic [31:0] rt,
                                 input logic [31:0] rd, output bit err, output bit ld,
                                 output logic [3:0] be, output logic [31:0] wd,
                                 output logic [31:0] data);
      int b;
      logic [7:0] rb [4];
      logic [7:0] rtb [4];
      logic [7:0] res [4];
      logic [15:0] h;
      b = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) begin
         rb[i]  = rd[8*i +: 8];
         rtb[i] = rt[8*i +: 8];
         res[i] = 8'd0;
      end
      err = 0; ld = 0; be = 4'd0; wd = 32'd0; data = 32'd0;
      case (op)
         4'd0, 4'd1: begin
            ld = 1; be[b] = 1'b1;
            data = (op == 4'd0) ? 32'($signed(rb[b])) : {24'd0, rb[b]};
         end
         4'd2, 4'd3: begin
            if (b % 2 != 0) err = 1;
            else begin
               ld = 1; be[b] = 1'b1; be[b+1] = 1'b1;
               h = {rb[b+1], rb[b]};
               data = (op == 4'd2) ? 32'($signed(h)) : {16'd0, h};
            end
         end
         4'd4: begin
            if (b != 0) err = 1;
            else begin ld = 1; be = 4'hF; data = rd; end
         end
         4'd5: begin be[b] = 1'b1; wd = {4{wd_in[7:0]}}; end
         4'd6: begin
            if (b % 2 != 0) err = 1;
            else begin be[b] = 1'b1; be[b+1] = 1'b1; wd = {2{wd_in[15:0]}}; end
         end
         4'd7: begin
            if (b != 0) err = 1;
            else begin be = 4'hF; wd = wd_in; end
         end
`ifdef LSU_UNALIGNED_EN
         4'd8: begin
            ld = 1;
            for (int i = 0; i < 4; i++) begin
               be[i] = (i <= b);
               if (i >= 3 - b) res[i] = rb[i - (3 - b)];
               else            res[i] = rtb[i];
            end
            data = {res[3], res[2], res[1], res[0]};
         end
         4'd9: begin
            ld = 1;
            for (int i = 0; i < 4; i++) begin
               be[i] = (i >= b);
               if (i + b <= 3) res[i] = rb[i + b];
               else            res[i] = rtb[i];
            end
            data = {res[3], res[2], res[1], res[0]};
         end
`endif
         default: err = 1;
      endcase
      if (err) begin ld = 0; be = 4'd0; wd = 32'd0; data = 32'd0; end
   endfunction

   // Per-cycle compare against the expectation for cycle k after acceptance.
   always @(negedge clk) begin
      bit bus;
      if (act) begin
         bus = !e_err && (k <= e_nwait + 1);
         chk("read", 32'(read), 32'(bus && e_ld));
         chk("write", 32'(write), 32'(bus && !e_ld));
         if (bus) begin
            chk("address", address, e_addr);
            chk("byteenable", 32'(byteenable), 32'(e_be));
            if (!e_ld) chk("writedata", writedata, e_wd);
         end
         chk("resp_valid", 32'(resp_valid), 32'(k == e_lat));
         chk("req_ready", 32'(req_ready), 32'(k > e_lat));
         if (k == e_lat) begin
            chk("resp_err", 32'(resp_err), 32'(e_err));
            chk("resp_data", resp_data, e_data);
         end
         if (resp_valid) begin
            rv_cnt++;
            last_data = resp_data;
            last_err  = resp_err;
         end
         if (write) wr_cnt++;
      end
   end

   task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rt, input logic [31:0] rd, input int nwait);
      model(op, addr, wd, rt, rd, e_err, e_ld, e_be, e_wd, e_data);
      e_addr  = {addr[31:2], 2'b00};
      e_nwait = nwait;
      e_lat   = e_err ? 1 : (e_ld ? nwait + 3 : nwait + 2);
      wr_cnt = 0; rv_cnt = 0; last_data = 32'd0; last_err = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
      waitrequest = (nwait > 0);
      readdata = POISON;
      @(posedge clk); #1;
      req_valid = 1'b0;
      act = 1'b1;
      for (int c = 1; c <= e_lat + 1; c++) begin
         k = c;
         waitrequest = (c <= nwait) && !e_err;
         readdata = (e_ld && c == nwait + 2) ? rd : POISON;
         @(negedge clk);
         @(posedge clk); #1;
      end
      act = 1'b0;
      waitrequest = 1'b0;
      chk("resp_count", 32'(rv_cnt), 32'd1);
   endtask

   initial begin
      // reset values
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_read", 32'(read), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_byteenable", 32'(byteenable), 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run(4'd4, 32'h0000_0104, 32'd0, 32'd0, 32'hDEAD_BEEF, 0);
      chk("lw_lit", last_data, 32'hDEAD_BEEF);
      run(4'd0, 32'h0000_0107, 32'd0, 32'd0, 32'h8011_2233, 0);
      chk("lb_lit", last_data, 32'hFFFF_FF80);
      run(4'd1, 32'h0000_0107, 32'd0, 32'd0, 32'h8011_2233, 0);
      chk("lbu_lit", last_data, 32'h0000_0080);
      run(4'd6, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 32'd0, 3);
      chk("sh_write_cycles", 32'(wr_cnt), 32'd4);
      run(4'd4, 32'h0000_0101, 32'd0, 32'd0, 32'h1111_1111, 0);
      chk("lw_mis_lit", 32'(last_err), 32'd1);
      run(4'd2, 32'h0000_0103, 32'd0, 32'd0, 32'h1111_1111, 0);
      chk("lh_mis_lit", 32'(last_err), 32'd1);
      run(4'd8, 32'h0000_0101, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
`ifdef LSU_UNALIGNED_EN
      chk("lwl_lit", last_data, 32'h2211_CCDD);
`else
      chk("lwl_illegal_lit", 32'(last_err), 32'd1);
`endif
      run(4'd9, 32'h0000_0102, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 1);
`ifdef LSU_UNALIGNED_EN
      chk("lwr_lit", last_data, 32'hAABB_4433);
`else
      chk("lwr_illegal_lit", 32'(last_err), 32'd1);
`endif
      run(4'd3, 32'h0000_0106, 32'd0, 32'd0, 32'h8001_7F00, 0);
      chk("lhu_lit", last_data, 32'h0000_8001);
      run(4'd2, 32'h0000_0106, 32'd0, 32'd0, 32'h8001_7F00, 2);
      chk("lh_lit", last_data, 32'hFFFF_8001);
      run(4'd2, 32'h0000_0104, 32'd0, 32'd0, 32'h8001_7F00, 0);
      run(4'd5, 32'h0000_0103, 32'h0000_00A5, 32'd0, 32'd0, 0);
      run(4'd5, 32'h0000_0100, 32'h0000_0012, 32'd0, 32'd0, 1);
      run(4'd7, 32'h0000_0108, 32'h0BAD_F00D, 32'd0, 32'd0, 1);
      run(4'd4, 32'h0000_0110, 32'd0, 32'd0, 32'h0123_4567, 2);
      run(4'd7, 32'h0000_010A, 32'h1, 32'd0, 32'd0, 0);
      run(4'd6, 32'h0000_0201, 32'h1, 32'd0, 32'd0, 0);
      run(4'hC, 32'h0000_0100, 32'h1, 32'd0, 32'd0, 0);
      chk("illegal_lit", 32'(last_err), 32'd1);

      // reset in the middle of a stalled load
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd4; req_addr = 32'h0000_0300; waitrequest = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_read_before", 32'(read), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_read", 32'(read), 32'd0);
      chk("abort_write", 32'(write), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_resp", 32'(resp_valid), 32'd0);
      end
      rst_n = 1'b1; waitrequest = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_ready", 32'(req_ready), 32'd1);
         chk("abort_no_resp_after", 32'(resp_valid), 32'd0);
      end

      run(4'd4, 32'h0000_0104, 32'd0, 32'd0, 32'hCAFE_F00D, 0);
      chk("post_reset_lit", last_data, 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
Load/store unit that sits directly upstream of mips_cpu_memory_bus, between the CPU datapath and the memory bus.
- Takes one load/store request at a time from the datapath.
- Drives the bus with a word-aligned address, byteenable and lane-replicated writedata, and holds the request while waitrequest is high.
- For loads, captures readdata, then extracts, sign- or zero-extends and merges the result before returning it.
- Detects misaligned accesses and reports them without issuing any bus cycle.

Parameters:
READ_LATENCY, 1, cycles from the accepted read (read=1, waitrequest=0) to valid readdata; legal values 0 or 1.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  datapath request strobe
req_ready  out  1  LSU can accept a request
req_op  in  4  operation code (lsu_op_t)
req_addr  in  32  byte address
req_wdata  in  32  store data (rt value)
req_rt_old  in  32  current rt value, used for LWL/LWR merge
resp_valid  out  1  one-cycle response pulse
resp_data  out  32  load result; 0 for stores
resp_err  out  1  misaligned or illegal op, qualified by resp_valid
address  out  32  bus word address, req_addr with bits [1:0] forced to 0
read  out  1  bus read strobe
write  out  1  bus write strobe
byteenable  out  4  bus byte lanes; bit i selects writedata[8i+7:8i]
writedata  out  32  bus store data
waitrequest  in  1  bus stall
readdata  in  32  bus load data

Behaviour:
- Reset (asynchronous, on rst_n low):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, read and write = 0.
  - resp_data, address, byteenable and writedata = 0.
  - Reset mid-transaction aborts the transaction: read/write drop immediately and no response is produced.
- States: IDLE, BUS, WAIT_DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the operation fields.
  - Misaligned or illegal request: go to RESP with err=1 and no bus cycle.
  - Otherwise: go to BUS.
- BUS:
  - Drive read or write, plus address, byteenable and writedata, from registers.
  - All bus outputs are held stable while waitrequest=1.
  - When waitrequest=0:
    - Store: go to RESP.
    - Load with READ_LATENCY=0: capture readdata this cycle, go to RESP.
    - Load with READ_LATENCY=1: go to WAIT_DATA.
- WAIT_DATA: read=0; capture readdata; go to RESP.
- RESP: resp_valid=1 for exactly one cycle; return to IDLE. req_ready=0 in every state except IDLE.
- Latency: minimum request-to-resp_valid is 2 cycles (store), 3 cycles (load with READ_LATENCY=1), or 1 cycle (error).
- Lanes are little-endian; b = req_addr[1:0].
  - Byte ops: byteenable = 1<<b.
  - Half ops: 4'b0011 (b=0) or 4'b1100 (b=2).
  - Word ops: 4'b1111.
- Store data is replicated across lanes:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
- Load extraction:
  - LB/LBU: byte at lane b, sign- or zero-extended.
  - LH/LHU: half at lane b/2, sign- or zero-extended.
  - LW: full word.
  - Byteenable lanes that are not enabled are ignored.
- Misalignment rules: half op with b[0]=1 is an error; word op with b!=0 is an error. Codes not defined in lsu_op_t are also errors. On error, resp_data=0.
- Simultaneous events: req_valid asserted outside IDLE is ignored; the datapath must hold the request until it sees req_ready.

Optional Feature:
LSU_UNALIGNED_EN.
- Defined: LWL and LWR are supported.
  - LWL: byteenable lanes 0..b; result = (readdata << 8*(3-b)) merged with req_rt_old in the low (3-b) bytes.
  - LWR: byteenable lanes b..3; result = (readdata >> 8*b) merged with req_rt_old in the high b bytes.
  - Neither op is ever misaligned.
- Not defined: LWL and LWR codes are illegal and return resp_err=1.

Decomposition:
- Package mips_cpu_lsu_pkg holds:
  - lsu_op_t (4-bit): LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7, LWL=8, LWR=9.
  - lsu_state_t.
  - Helper functions is_load(op) and is_misaligned(op, b).
- One combinational sub-module, mips_cpu_lsu_align, implements load extraction, extension and the LWL/LWR merge. It takes op, b, readdata and rt_old, and outputs data.

Test Plan:
- LW addr=0x00000104, memory word 0xDEADBEEF, waitrequest=0 -> address=0x104, byteenable=4'b1111, resp_data=0xDEADBEEF, resp_err=0, resp_valid at cycle 3.
- LB addr=0x107, lane 3 byte 0x80 -> byteenable=4'b1000, resp_data=0xFFFFFF80; repeat with LBU -> resp_data=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, waitrequest high 3 cycles -> write held 4 cycles, address=0x200, byteenable=4'b1100, writedata=0xABCDABCD, resp_valid once.
- LW addr=0x101 -> no read/write asserted, resp_valid with resp_err=1 one cycle after accept; LH addr=0x103 -> same.
- rst_n low during BUS with waitrequest=1 -> read drops to 0 immediately, no resp_valid, req_ready=1 after rst_n release.
- With LSU_UNALIGNED_EN: LWL addr=0x101, readdata=0x44332211, rt_old=0xAABBCCDD -> byteenable=4'b0011, resp_data=0x2211CCDD. Without LSU_UNALIGNED_EN: same request -> resp_err=1.
